// File: rtl/frame_buffer_coordinator.sv
// Rotating frame-buffer manager: hands free buffers to the writer, tracks the latest completed
// frame and grants it to the host readout path so the writer and reader never share a buffer.
module frame_buffer_coordinator #(
    parameter int unsigned NUM_BUFFERS = 4,
    parameter logic [29:0] BASE_ADDR   = 30'h0,
    parameter logic [29:0] BUF_STRIDE  = 30'h0080_0000
) (
    input  logic        clk,
    input  logic        reset_clk,
    input  logic [31:0] frame_bytes,
    input  logic        wr_frame_start,
    input  logic        wr_frame_done,
    output logic [29:0] wr_addr,
    output logic        wr_buf_valid,
    input  logic        host_rd_request,
    input  logic        host_rd_done,
    output logic        readout_start,
    output logic [29:0] readout_addr,
    output logic [31:0] readout_count,
    output logic        readout_done,
    output logic        frame_ready,
    output logic        rd_busy,
    output logic [15:0] skip_count
);
    typedef enum logic [1:0] {BufFree, BufWriting, BufReady, BufReading} buf_state_e;
    typedef enum logic [1:0] {CtlIdle, CtlPend, CtlBusy} ctl_state_e;

    buf_state_e  buf_q [NUM_BUFFERS];
    buf_state_e  buf_d [NUM_BUFFERS];
    ctl_state_e  ctl_q, ctl_d;
    logic [29:0] wr_addr_q, wr_addr_d;
    logic [29:0] readout_addr_q, readout_addr_d;
    logic [31:0] readout_count_q, readout_count_d;
    logic [15:0] skip_count_q, skip_count_d;
    logic        wr_buf_valid_q, wr_buf_valid_d;
    logic        readout_start_q, readout_start_d;
    logic        readout_done_q, readout_done_d;
    logic        frame_ready_q, frame_ready_d;
    logic        rd_busy_q, rd_busy_d;

    logic was_writing, displaced, alloc_found, ready_found, grant_req;

    function automatic logic [29:0] buf_addr(input int idx);
        logic [29:0] idx30;
        idx30 = 30'(idx);
        return BASE_ADDR + idx30 * BUF_STRIDE;
    endfunction

    always_comb begin
        buf_d           = buf_q;
        ctl_d           = ctl_q;
        wr_addr_d       = wr_addr_q;
        readout_addr_d  = readout_addr_q;
        readout_count_d = readout_count_q;
        skip_count_d    = skip_count_q;
        readout_start_d = 1'b0;
        readout_done_d  = 1'b0;
        wr_buf_valid_d  = 1'b0;
        frame_ready_d   = 1'b0;
        rd_busy_d       = 1'b0;
        was_writing     = 1'b0;
        displaced       = 1'b0;
        alloc_found     = 1'b0;
        ready_found     = 1'b0;

        // Reader release goes first so its buffer can be reallocated this same cycle.
        if (ctl_q == CtlBusy && host_rd_done) begin
            for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
                if (buf_d[i] == BufReading) buf_d[i] = BufFree;
            end
            readout_done_d = 1'b1;
            ctl_d          = CtlIdle;
        end

        for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
            if (buf_q[i] == BufWriting) was_writing = 1'b1;
        end

        if (wr_frame_done && was_writing) begin
            for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
                if (buf_d[i] == BufReady) begin
                    buf_d[i]  = BufFree;
                    displaced = 1'b1;
                end else if (buf_d[i] == BufWriting) begin
                    buf_d[i] = BufReady;
                end
            end
            if (displaced && skip_count_q != 16'hFFFF) skip_count_d = skip_count_q + 16'd1;
        end

        // A start while still writing restarts the same buffer: nothing to allocate.
        if (wr_frame_start && !(was_writing && !wr_frame_done)) begin
            for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
                if (!alloc_found && buf_d[i] == BufFree) begin
                    alloc_found = 1'b1;
                    buf_d[i]    = BufWriting;
                    wr_addr_d   = buf_addr(i);
                end
            end
        end

        grant_req = (ctl_q == CtlIdle && host_rd_request) || ctl_q == CtlPend;
        if (grant_req) begin
            for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
                if (buf_d[i] == BufReady) begin
                    ready_found    = 1'b1;
                    buf_d[i]       = BufReading;
                    readout_addr_d = buf_addr(i);
                end
            end
            if (ready_found) begin
                readout_count_d = frame_bytes;
                readout_start_d = 1'b1;
                ctl_d           = CtlBusy;
            end else begin
                ctl_d = CtlPend;
            end
        end

        for (int i = 0; i < int'(NUM_BUFFERS); i++) begin
            if (buf_d[i] == BufWriting) wr_buf_valid_d = 1'b1;
            if (buf_d[i] == BufReady)   frame_ready_d  = 1'b1;
            if (buf_d[i] == BufReading) rd_busy_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_clk) begin
            for (int i = 0; i < int'(NUM_BUFFERS); i++) buf_q[i] <= BufFree;
            ctl_q           <= CtlIdle;
            wr_addr_q       <= '0;
            readout_addr_q  <= '0;
            readout_count_q <= '0;
            skip_count_q    <= '0;
            wr_buf_valid_q  <= 1'b0;
            readout_start_q <= 1'b0;
            readout_done_q  <= 1'b0;
            frame_ready_q   <= 1'b0;
            rd_busy_q       <= 1'b0;
        end else begin
            buf_q           <= buf_d;
            ctl_q           <= ctl_d;
            wr_addr_q       <= wr_addr_d;
            readout_addr_q  <= readout_addr_d;
            readout_count_q <= readout_count_d;
            skip_count_q    <= skip_count_d;
            wr_buf_valid_q  <= wr_buf_valid_d;
            readout_start_q <= readout_start_d;
            readout_done_q  <= readout_done_d;
            frame_ready_q   <= frame_ready_d;
            rd_busy_q       <= rd_busy_d;
        end
    end

    assign wr_addr       = wr_addr_q;
    assign wr_buf_valid  = wr_buf_valid_q;
    assign readout_start = readout_start_q;
    assign readout_addr  = readout_addr_q;
    assign readout_count = readout_count_q;
    assign readout_done  = readout_done_q;
    assign frame_ready   = frame_ready_q;
    assign rd_busy       = rd_busy_q;
    assign skip_count    = skip_count_q;

endmodule

// File: tb/tb_frame_buffer_coordinator.sv
// Bench for frame_buffer_coordinator: directed vector table, hand-written corner sequences and a
// randomized run checked against a buffer-ownership reference model.
module tb_frame_buffer_coordinator;
    localparam int          NB     = 4;
    localparam logic [29:0] BASE   = 30'h0;
    localparam logic [29:0] STRIDE = 30'h0080_0000;

    logic        clk = 1'b0;
    logic        reset_clk;
    logic [31:0] frame_bytes;
    logic        wr_frame_start, wr_frame_done, host_rd_request, host_rd_done;
    logic [29:0] wr_addr, readout_addr;
    logic [31:0] readout_count;
    logic [15:0] skip_count;
    logic        wr_buf_valid, readout_start, readout_done, frame_ready, rd_busy;

    always #5 clk = ~clk;

    frame_buffer_coordinator #(
        .NUM_BUFFERS(NB),
        .BASE_ADDR  (BASE),
        .BUF_STRIDE (STRIDE)
    ) dut (
        .clk            (clk),
        .reset_clk      (reset_clk),
        .frame_bytes    (frame_bytes),
        .wr_frame_start (wr_frame_start),
        .wr_frame_done  (wr_frame_done),
        .wr_addr        (wr_addr),
        .wr_buf_valid   (wr_buf_valid),
        .host_rd_request(host_rd_request),
        .host_rd_done   (host_rd_done),
        .readout_start  (readout_start),
        .readout_addr   (readout_addr),
        .readout_count  (readout_count),
        .readout_done   (readout_done),
        .frame_ready    (frame_ready),
        .rd_busy        (rd_busy),
        .skip_count     (skip_count)
    );

    typedef struct packed {
        logic        start, done, req, rdone;
        logic [31:0] fb;
    } in_t;

    typedef struct packed {
        logic        wv;
        logic [29:0] waddr;
        logic        rs, rdn, fr, busy;
        logic [29:0] raddr;
        logic [31:0] rcnt;
        logic [15:0] skip;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: which buffer index the writer, the ready slot and the reader hold (-1 = none).
    int   m_w, m_r, m_rd;
    bit   m_pend;
    out_t m;

    function automatic logic [29:0] addr_of(input int i);
        longint a;
        a = longint'(BASE) + longint'(i) * longint'(STRIDE);
        return a[29:0];
    endfunction

    function automatic void model_reset();
        m_w = -1; m_r = -1; m_rd = -1; m_pend = 1'b0;
        m = '0;
    endfunction

    function automatic void model_step(input in_t x);
        bit was_idle;
        was_idle = (m_rd < 0) && !m_pend;
        m.rs  = 1'b0;
        m.rdn = 1'b0;
        if (m_rd >= 0 && x.rdone) begin
            m_rd  = -1;
            m.rdn = 1'b1;
        end
        if (x.done && m_w >= 0) begin
            if (m_r >= 0 && m.skip != 16'hFFFF) m.skip = m.skip + 16'd1;
            m_r = m_w;
            m_w = -1;
        end
        if (x.start && m_w < 0) begin
            for (int i = NB - 1; i >= 0; i--) begin
                if (i != m_r && i != m_rd) m_w = i;
            end
            m.waddr = addr_of(m_w);
        end
        if ((was_idle && x.req) || m_pend) begin
            if (m_r >= 0) begin
                m_rd    = m_r;
                m_r     = -1;
                m_pend  = 1'b0;
                m.rs    = 1'b1;
                m.raddr = addr_of(m_rd);
                m.rcnt  = x.fb;
            end else begin
                m_pend = 1'b1;
            end
        end
        m.wv   = (m_w >= 0);
        m.fr   = (m_r >= 0);
        m.busy = (m_rd >= 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input out_t e);
        chk({tag, ".wr_buf_valid"}, 32'(wr_buf_valid), 32'(e.wv));
        chk({tag, ".wr_addr"}, 32'(wr_addr), 32'(e.waddr));
        chk({tag, ".readout_start"}, 32'(readout_start), 32'(e.rs));
        chk({tag, ".readout_done"}, 32'(readout_done), 32'(e.rdn));
        chk({tag, ".frame_ready"}, 32'(frame_ready), 32'(e.fr));
        chk({tag, ".rd_busy"}, 32'(rd_busy), 32'(e.busy));
        chk({tag, ".readout_addr"}, 32'(readout_addr), 32'(e.raddr));
        chk({tag, ".readout_count"}, readout_count, e.rcnt);
        chk({tag, ".skip_count"}, 32'(skip_count), 32'(e.skip));
    endtask

    // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
    task automatic apply(input in_t x, input logic rst);
        reset_clk       = rst;
        wr_frame_start  = x.start;
        wr_frame_done   = x.done;
        host_rd_request = x.req;
        host_rd_done    = x.rdone;
        frame_bytes     = x.fb;
        @(posedge clk);
        #1;
        reset_clk       = 1'b0;
        wr_frame_start  = 1'b0;
        wr_frame_done   = 1'b0;
        host_rd_request = 1'b0;
        host_rd_done    = 1'b0;
    endtask

    task automatic cyc(input string tag, input in_t x);
        apply(x, 1'b0);
        model_step(x);
        cmp(tag, m);
    endtask

    task automatic do_reset(input string tag, input in_t x);
        apply(x, 1'b1);
        model_reset();
        cmp(tag, m);
    endtask

    function automatic in_t mk(input bit s, input bit d, input bit q, input bit r,
                               input logic [31:0] fb);
        in_t x;
        x.start = s; x.done = d; x.req = q; x.rdone = r; x.fb = fb;
        return x;
    endfunction

    function automatic vec_t v(input bit s, input bit d, input bit q, input bit r,
                               input logic [31:0] fb, input bit wv, input logic [29:0] wa,
                               input bit rs, input bit rdn, input bit fr, input bit busy,
                               input logic [29:0] ra, input logic [31:0] rc,
                               input logic [15:0] sk);
        vec_t t;
        t.i = mk(s, d, q, r, fb);
        t.o = '{wv: wv, waddr: wa, rs: rs, rdn: rdn, fr: fr, busy: busy, raddr: ra, rcnt: rc,
                skip: sk};
        return t;
    endfunction

    vec_t tbl[$];
    in_t  idle;
    in_t  x;

    initial begin
        idle = mk(0, 0, 0, 0, 32'h0);
        reset_clk = 1'b1; wr_frame_start = 1'b0; wr_frame_done = 1'b0;
        host_rd_request = 1'b0; host_rd_done = 1'b0; frame_bytes = '0;

        // Basic write-then-read, writer outrunning reader, request before a frame, spurious pulses.
        tbl.push_back(v(1,0,0,0,32'h0,        1,30'h0,      0,0,0,0, 30'h0,32'h0,        16'd0));
        tbl.push_back(v(0,1,0,0,32'h0,        0,30'h0,      0,0,1,0, 30'h0,32'h0,        16'd0));
        tbl.push_back(v(0,0,1,0,32'h0012C000, 0,30'h0,      1,0,0,1, 30'h0,32'h0012C000, 16'd0));
        tbl.push_back(v(0,0,0,0,32'h0,        0,30'h0,      0,0,0,1, 30'h0,32'h0012C000, 16'd0));
        tbl.push_back(v(0,0,0,1,32'h0,        0,30'h0,      0,1,0,0, 30'h0,32'h0012C000, 16'd0));
        tbl.push_back(v(0,0,0,0,32'h0,        0,30'h0,      0,0,0,0, 30'h0,32'h0012C000, 16'd0));
        tbl.push_back(v(1,0,0,0,32'h0,        1,30'h0,      0,0,0,0, 30'h0,32'h0012C000, 16'd0));
        tbl.push_back(v(0,1,0,0,32'h0,        0,30'h0,      0,0,1,0, 30'h0,32'h0012C000, 16'd0));
        tbl.push_back(v(1,0,0,0,32'h0,        1,30'h800000, 0,0,1,0, 30'h0,32'h0012C000, 16'd0));
        tbl.push_back(v(0,1,0,0,32'h0,        0,30'h800000, 0,0,1,0, 30'h0,32'h0012C000, 16'd1));
        tbl.push_back(v(1,0,0,0,32'h0,        1,30'h0,      0,0,1,0, 30'h0,32'h0012C000, 16'd1));
        tbl.push_back(v(0,1,0,0,32'h0,        0,30'h0,      0,0,1,0, 30'h0,32'h0012C000, 16'd2));
        tbl.push_back(v(0,0,1,0,32'h100,      0,30'h0,      1,0,0,1, 30'h0,32'h100,      16'd2));
        tbl.push_back(v(0,0,0,1,32'h0,        0,30'h0,      0,1,0,0, 30'h0,32'h100,      16'd2));
        tbl.push_back(v(0,0,1,0,32'h555,      0,30'h0,      0,0,0,0, 30'h0,32'h100,      16'd2));
        tbl.push_back(v(0,0,0,0,32'h0,        0,30'h0,      0,0,0,0, 30'h0,32'h100,      16'd2));
        tbl.push_back(v(1,0,0,0,32'h0,        1,30'h0,      0,0,0,0, 30'h0,32'h100,      16'd2));
        tbl.push_back(v(0,1,0,0,32'h2000,     0,30'h0,      1,0,0,1, 30'h0,32'h2000,     16'd2));
        tbl.push_back(v(0,0,0,0,32'h0,        0,30'h0,      0,0,0,1, 30'h0,32'h2000,     16'd2));
        tbl.push_back(v(0,0,1,0,32'h9,        0,30'h0,      0,0,0,1, 30'h0,32'h2000,     16'd2));
        tbl.push_back(v(0,0,0,1,32'h0,        0,30'h0,      0,1,0,0, 30'h0,32'h2000,     16'd2));
        tbl.push_back(v(0,0,0,1,32'h0,        0,30'h0,      0,0,0,0, 30'h0,32'h2000,     16'd2));
        tbl.push_back(v(0,1,0,0,32'h0,        0,30'h0,      0,0,0,0, 30'h0,32'h2000,     16'd2));

        do_reset("reset0", idle);
        foreach (tbl[k]) begin
            apply(tbl[k].i, 1'b0);
            cmp($sformatf("vec%0d", k), tbl[k].o);
        end

        // Isolation: buffer 0 is being read while the writer runs four frames.
        do_reset("iso.reset", idle);
        cyc("iso.s", mk(1, 0, 0, 0, 0));
        cyc("iso.d", mk(0, 1, 0, 0, 0));
        cyc("iso.q", mk(0, 0, 1, 0, 32'h4000));
        for (int f = 0; f < 4; f++) begin
            cyc("iso.fs", mk(1, 0, 0, 0, 0));
            chk("iso.wr_addr_not_0", 32'(wr_addr != 30'h0), 32'd1);
            cyc("iso.fd", mk(0, 1, 0, 0, 0));
        end
        cyc("iso.rdone", mk(0, 0, 0, 1, 0));
        cyc("iso.realloc", mk(1, 0, 0, 0, 0));
        chk("iso.realloc_addr", 32'(wr_addr), 32'h0);

        // Done and request together, with an older ready frame present.
        do_reset("sim.reset", idle);
        cyc("sim.s0", mk(1, 0, 0, 0, 0));
        cyc("sim.d0", mk(0, 1, 0, 0, 0));
        cyc("sim.s1", mk(1, 0, 0, 0, 0));
        cyc("sim.dq", mk(0, 1, 1, 0, 32'h77));
        chk("sim.readout_addr", 32'(readout_addr), 32'h0080_0000);
        chk("sim.skip_count", 32'(skip_count), 32'd1);
        chk("sim.readout_start", 32'(readout_start), 32'd1);

        // Reset while busy, with host_rd_done arriving in the same cycle.
        do_reset("rst.reset", idle);
        cyc("rst.s", mk(1, 0, 0, 0, 0));
        cyc("rst.d", mk(0, 1, 0, 0, 0));
        cyc("rst.q", mk(0, 0, 1, 0, 32'h1234));
        cyc("rst.s2", mk(1, 0, 0, 0, 0));
        do_reset("rst.mid", mk(0, 0, 0, 1, 32'h0));
        cyc("rst.after", idle);
        chk("rst.no_done", 32'(readout_done), 32'd0);

        // Randomized traffic against the model; start and done never share a cycle.
        do_reset("rnd.reset", idle);
        for (int n = 0; n < 3000; n++) begin
            x.start = ($urandom_range(0, 3) == 0);
            x.done  = !x.start && ($urandom_range(0, 3) == 0);
            x.req   = ($urandom_range(0, 5) == 0);
            x.rdone = ($urandom_range(0, 4) == 0);
            x.fb    = $urandom();
            cyc($sformatf("rnd%0d", n), x);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
